// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory stage (sizes, mem_ctrl fields, branch ops, FSM states)
package mem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  localparam int CTL_LOAD  = 0;
  localparam int CTL_STORE = 1;
  localparam int CTL_UNS   = 2;
  localparam int CTL_SIZE  = 3;
  localparam int CTL_BOP   = 5;
  localparam logic [1:0] BOP_BEQ = 2'b01;
  localparam logic [1:0] BOP_BNE = 2'b10;
  typedef enum logic {S_IDLE, S_REQ} state_e;
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    return sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: load lane extraction/extension, store lane replication, byte enables and alignment check
module mem_align import mem_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   rt_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   load_data,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN/8-1:0] be,
  output logic              misalign
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  logic [OW-1:0]   off;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] keep;
  logic [7:0]      mask8;
  logic            sgn;
  always_comb begin
    off = addr[OW-1:0];
    sh = rdata >> {off, 3'b000};
    mask8 = size_mask(size);
    be = mask8[NB-1:0] << off;
    // dword on a 32-bit datapath cannot be issued, so it is reported like a misaligned access
    misalign = (size == SZ_D && XLEN == 32) || (size == SZ_H && addr[0]) ||
               (size == SZ_W && |addr[1:0]) || (size == SZ_D && |addr[2:0]);
    wdata = size == SZ_B ? {NB{rt_data[7:0]}} : size == SZ_H ? {NB/2{rt_data[15:0]}} :
            size == SZ_W ? {XLEN/32{rt_data[31:0]}} : rt_data;
    keep = ~({XLEN{1'b1}} << (8 << size));
    sgn = size == SZ_B ? sh[7] : size == SZ_H ? sh[15] : size == SZ_W ? sh[31] : sh[XLEN-1];
    load_data = (sh & keep) | ({XLEN{sgn & ~uns}} & ~keep);
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory stage with branch resolution, req/ack cache access and MEM/WB register
module mem_lsu import mem_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int BPT_IDX_W = 8,
  parameter int REG_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic [XLEN-1:0]      branch_pc,
  input  logic [XLEN-1:0]      next_pc,
  input  logic [6:0]           mem_ctrl,
  input  logic [1:0]           wb_ctrl,
  input  logic [XLEN-1:0]      rt_data,
  input  logic [XLEN-1:0]      alu_out,
  input  logic [XLEN-1:0]      recover_taken,
  input  logic                 prediction,
  input  logic [REG_W-1:0]     write_reg,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [XLEN/8-1:0]    mem_be,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 stall,
  output logic                 flush,
  output logic                 branch_result,
  output logic                 bpt_we,
  output logic [BPT_IDX_W-1:0] bpt_waddr,
  output logic [XLEN:0]        bpt_wdata,
  output logic                 misalign,
  output logic                 wb_valid,
  output logic [XLEN-1:0]      wb_mem_out,
  output logic [XLEN-1:0]      wb_alu_out,
  output logic [REG_W-1:0]     wb_write_reg,
  output logic [1:0]           wb_ctrl_q
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic              wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]   wb_mem_out_q, wb_mem_out_d, wb_alu_out_q, wb_alu_out_d;
  logic [REG_W-1:0]  wb_write_reg_q, wb_write_reg_d;
  logic [1:0]        wb_ctrl_d, wb_ctrl_r;
  logic [XLEN-1:0]   ld_data, st_wdata;
  logic [NB-1:0]     st_be;
  logic              mis_raw, is_ld, is_st, mem_op;
  logic [1:0]        bop;
  logic              unused_ok;
  mem_align #(.XLEN(XLEN)) u_align (
    .size(mem_ctrl[CTL_SIZE +: 2]), .uns(mem_ctrl[CTL_UNS]), .addr(alu_out),
    .rt_data(rt_data), .rdata(mem_rdata), .load_data(ld_data), .wdata(st_wdata),
    .be(st_be), .misalign(mis_raw)
  );
  assign is_st = mem_ctrl[CTL_STORE];
  assign is_ld = mem_ctrl[CTL_LOAD] & ~is_st;
  assign mem_op = is_ld | is_st;
  assign bop = mem_ctrl[CTL_BOP +: 2];
  assign misalign = ex_valid & mem_op & mis_raw;
  assign branch_result = ex_valid & ((bop == BOP_BEQ && alu_out == '0) || (bop == BOP_BNE && alu_out != '0));
  assign flush = ex_valid & ((branch_result != prediction) | (branch_result & (next_pc != recover_taken)));
  assign bpt_we = ex_valid & (bop == BOP_BEQ || bop == BOP_BNE);
  assign bpt_waddr = branch_pc[BPT_IDX_W+1:2];
  assign bpt_wdata = {recover_taken, branch_result};
  assign unused_ok = ^{branch_pc[XLEN-1:BPT_IDX_W+2], branch_pc[1:0]};
  always_comb begin
    state_d = state_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d = mem_be_q;
    stall = 1'b0;
    if (state_q == S_IDLE) begin
      if (ex_valid & mem_op & ~mis_raw) begin
        stall = 1'b1;
        state_d = S_REQ;
        mem_req_d = 1'b1;
        mem_we_d = is_st;
        mem_addr_d = {alu_out[XLEN-1:OW], {OW{1'b0}}};
        mem_wdata_d = st_wdata;
        mem_be_d = st_be;
      end
    end else begin
      stall = ~mem_ack;
      if (mem_ack) begin
        state_d = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d = 1'b0;
      end
    end
    wb_valid_d = stall ? wb_valid_q : ex_valid & ~misalign;
    wb_mem_out_d = stall ? wb_mem_out_q : ld_data;
    wb_alu_out_d = stall ? wb_alu_out_q : alu_out;
    wb_write_reg_d = stall ? wb_write_reg_q : write_reg;
    wb_ctrl_d = stall ? wb_ctrl_r : wb_ctrl;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_be_q <= '0;
      wb_valid_q <= 1'b0;
      wb_mem_out_q <= '0;
      wb_alu_out_q <= '0;
      wb_write_reg_q <= '0;
      wb_ctrl_r <= '0;
    end else begin
      state_q <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q <= mem_be_d;
      wb_valid_q <= wb_valid_d;
      wb_mem_out_q <= wb_mem_out_d;
      wb_alu_out_q <= wb_alu_out_d;
      wb_write_reg_q <= wb_write_reg_d;
      wb_ctrl_r <= wb_ctrl_d;
    end
  end
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be = mem_be_q;
  assign wb_valid = wb_valid_q;
  assign wb_mem_out = wb_mem_out_q;
  assign wb_alu_out = wb_alu_out_q;
  assign wb_write_reg = wb_write_reg_q;
  assign wb_ctrl_q = wb_ctrl_r;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed checks of mem_lsu at XLEN=32 and XLEN=64
module tb_mem_lsu;
  localparam logic [6:0] LW = 7'b0010001, LB = 7'b0000001, LBU = 7'b0000101, LH = 7'b0001001, LHU = 7'b0001101;
  localparam logic [6:0] SH = 7'b0001010, SB = 7'b0000010, SWL = 7'b0010011, LD = 7'b0011001;
  localparam logic [6:0] BEQ = 7'b0100000, BNE = 7'b1000000, NOBR = 7'b0000000;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic ev32, ev64, prediction, mem_ack;
  logic [6:0] mem_ctrl;
  logic [1:0] wb_ctrl;
  logic [4:0] write_reg;
  logic [63:0] pc, npc, tgt, rt, alu, rdata;
  logic req32, we32, stall32, flush32, br32, bptwe32, mis32, wbv32;
  logic [31:0] addr32, wdata32, wbm32, wba32;
  logic [3:0] be32;
  logic [7:0] bpta32, bpta64;
  logic [32:0] bptd32;
  logic [4:0] wbr32, wbr64;
  logic [1:0] wbc32, wbc64;
  logic req64, we64, stall64, flush64, br64, bptwe64, mis64, wbv64;
  logic [63:0] addr64, wdata64, wbm64, wba64;
  logic [7:0] be64;
  logic [64:0] bptd64;
  int total = 0, bad = 0, stalls;
  logic cap_req, cap_we;
  logic [63:0] cap_addr, cap_wdata;
  logic [7:0] cap_be;

  mem_lsu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ev32), .branch_pc(pc[31:0]), .next_pc(npc[31:0]),
    .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .rt_data(rt[31:0]), .alu_out(alu[31:0]),
    .recover_taken(tgt[31:0]), .prediction(prediction), .write_reg(write_reg),
    .mem_req(req32), .mem_we(we32), .mem_addr(addr32), .mem_wdata(wdata32), .mem_be(be32),
    .mem_ack(mem_ack), .mem_rdata(rdata[31:0]), .stall(stall32), .flush(flush32),
    .branch_result(br32), .bpt_we(bptwe32), .bpt_waddr(bpta32), .bpt_wdata(bptd32),
    .misalign(mis32), .wb_valid(wbv32), .wb_mem_out(wbm32), .wb_alu_out(wba32),
    .wb_write_reg(wbr32), .wb_ctrl_q(wbc32));
  mem_lsu #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .ex_valid(ev64), .branch_pc(pc), .next_pc(npc),
    .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .rt_data(rt), .alu_out(alu),
    .recover_taken(tgt), .prediction(prediction), .write_reg(write_reg),
    .mem_req(req64), .mem_we(we64), .mem_addr(addr64), .mem_wdata(wdata64), .mem_be(be64),
    .mem_ack(mem_ack), .mem_rdata(rdata), .stall(stall64), .flush(flush64),
    .branch_result(br64), .bpt_we(bptwe64), .bpt_waddr(bpta64), .bpt_wdata(bptd64),
    .misalign(mis64), .wb_valid(wbv64), .wb_mem_out(wbm64), .wb_alu_out(wba64),
    .wb_write_reg(wbr64), .wb_ctrl_q(wbc64));

  // Runs one memory op on the chosen instance; ack arrives in REQ cycle 'lat'.
  task automatic mem_op(input bit w, input logic [6:0] ctrl, input logic [63:0] a, d, r, input int lat);
    mem_ctrl = ctrl; alu = a; rt = d; rdata = r; mem_ack = 1'b0; ev32 = !w; ev64 = w; stalls = 0;
    #1 stalls += (w ? stall64 : stall32) ? 1 : 0;
    @(posedge clk); #1;
    cap_req = w ? req64 : req32; cap_we = w ? we64 : we32;
    cap_addr = w ? addr64 : {32'h0, addr32}; cap_wdata = w ? wdata64 : {32'h0, wdata32};
    cap_be = w ? be64 : {4'h0, be32};
    for (int c = 1; c <= lat; c++) begin
      mem_ack = (c == lat);
      #1 stalls += (w ? stall64 : stall32) ? 1 : 0;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; ev32 = 1'b0; ev64 = 1'b0;
  endtask

  task automatic test_reset;
    ev32 = 0; ev64 = 0; prediction = 0; mem_ack = 0; mem_ctrl = NOBR; wb_ctrl = 2'b11; write_reg = 5'd7;
    pc = 0; npc = 0; tgt = 0; rt = 0; alu = 0; rdata = 0;
    #12;
    total++; if (req32 !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", req32); end
    total++; if (we32 !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", we32); end
    total++; if (addr32 !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", addr32); end
    total++; if (be32 !== 4'h0) begin bad++; $display("FAIL rst_be got=%h want=0", be32); end
    total++; if (wbv32 !== 1'b0) begin bad++; $display("FAIL rst_wbv got=%b want=0", wbv32); end
    total++; if (wbc32 !== 2'b00) begin bad++; $display("FAIL rst_wbc got=%b want=0", wbc32); end
    total++; if (req64 !== 1'b0) begin bad++; $display("FAIL rst_req64 got=%b want=0", req64); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw;
    write_reg = 5'd9; wb_ctrl = 2'b10;
    mem_op(0, LW, 64'h100, 64'h0, 64'hDEADBEEF, 3);
    total++; if (stalls !== 3) begin bad++; $display("FAIL lw_stalls got=%0d want=3", stalls); end
    total++; if (cap_req !== 1'b1) begin bad++; $display("FAIL lw_req got=%b want=1", cap_req); end
    total++; if (cap_we !== 1'b0) begin bad++; $display("FAIL lw_we got=%b want=0", cap_we); end
    total++; if (cap_be !== 8'h0F) begin bad++; $display("FAIL lw_be got=%h want=0f", cap_be); end
    total++; if (cap_addr !== 64'h100) begin bad++; $display("FAIL lw_addr got=%h want=100", cap_addr); end
    total++; if (wbm32 !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", wbm32); end
    total++; if (wbv32 !== 1'b1) begin bad++; $display("FAIL lw_wbv got=%b want=1", wbv32); end
    total++; if (wbr32 !== 5'd9) begin bad++; $display("FAIL lw_wbr got=%0d want=9", wbr32); end
    total++; if (wbc32 !== 2'b10) begin bad++; $display("FAIL lw_wbc got=%b want=10", wbc32); end
    total++; if (req32 !== 1'b0) begin bad++; $display("FAIL lw_req_after got=%b want=0", req32); end
  endtask

  task automatic test_loads;
    mem_op(0, LB, 64'h103, 64'h0, 64'h80112233, 1);
    total++; if (stalls !== 1) begin bad++; $display("FAIL lb_stalls got=%0d want=1", stalls); end
    total++; if (wbm32 !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h want=ffffff80", wbm32); end
    total++; if (cap_be !== 8'h08) begin bad++; $display("FAIL lb_be got=%h want=08", cap_be); end
    mem_op(0, LBU, 64'h103, 64'h0, 64'h80112233, 1);
    total++; if (wbm32 !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h want=00000080", wbm32); end
    mem_op(0, LH, 64'h102, 64'h0, 64'h80112233, 2);
    total++; if (wbm32 !== 32'hFFFF8011) begin bad++; $display("FAIL lh_data got=%h want=ffff8011", wbm32); end
    mem_op(0, LHU, 64'h102, 64'h0, 64'h80112233, 1);
    total++; if (wbm32 !== 32'h00008011) begin bad++; $display("FAIL lhu_data got=%h want=00008011", wbm32); end
  endtask

  task automatic test_stores;
    mem_op(0, SH, 64'h102, 64'h0000ABCD, 64'h0, 1);
    total++; if (cap_wdata !== 64'hABCDABCD) begin bad++; $display("FAIL sh_wdata got=%h want=abcdabcd", cap_wdata); end
    total++; if (cap_be !== 8'h0C) begin bad++; $display("FAIL sh_be got=%h want=0c", cap_be); end
    total++; if (cap_we !== 1'b1) begin bad++; $display("FAIL sh_we got=%b want=1", cap_we); end
    total++; if (cap_addr !== 64'h100) begin bad++; $display("FAIL sh_addr got=%h want=100", cap_addr); end
    mem_op(0, SB, 64'h101, 64'h12345678, 64'h0, 1);
    total++; if (cap_wdata !== 64'h78787878) begin bad++; $display("FAIL sb_wdata got=%h want=78787878", cap_wdata); end
    total++; if (cap_be !== 8'h02) begin bad++; $display("FAIL sb_be got=%h want=02", cap_be); end
    mem_op(0, SWL, 64'h104, 64'h11223344, 64'h0, 1);
    total++; if (cap_we !== 1'b1) begin bad++; $display("FAIL store_wins_we got=%b want=1", cap_we); end
    total++; if (cap_wdata !== 64'h11223344) begin bad++; $display("FAIL store_wins_wdata got=%h want=11223344", cap_wdata); end
  endtask

  task automatic test_misalign;
    mem_ctrl = LW; alu = 64'h102; ev32 = 1; mem_ack = 1;
    #1;
    total++; if (mis32 !== 1'b1) begin bad++; $display("FAIL mis_lw got=%b want=1", mis32); end
    total++; if (stall32 !== 1'b0) begin bad++; $display("FAIL mis_stall got=%b want=0", stall32); end
    @(posedge clk); #1;
    total++; if (req32 !== 1'b0) begin bad++; $display("FAIL mis_req got=%b want=0", req32); end
    total++; if (wbv32 !== 1'b0) begin bad++; $display("FAIL mis_wbv got=%b want=0", wbv32); end
    mem_ack = 0; mem_ctrl = LD; alu = 64'h100;
    #1;
    total++; if (mis32 !== 1'b1) begin bad++; $display("FAIL mis_ld32 got=%b want=1", mis32); end
    ev32 = 0; ev64 = 1;
    #1;
    total++; if (mis64 !== 1'b0) begin bad++; $display("FAIL mis_ld64 got=%b want=0", mis64); end
    ev64 = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_branch;
    mem_ctrl = BEQ; alu = 0; prediction = 1; pc = 64'hABC; npc = 64'h200; tgt = 64'h400; ev32 = 1;
    #1;
    total++; if (br32 !== 1'b1) begin bad++; $display("FAIL beq_br got=%b want=1", br32); end
    total++; if (flush32 !== 1'b1) begin bad++; $display("FAIL beq_flush got=%b want=1", flush32); end
    total++; if (bptwe32 !== 1'b1) begin bad++; $display("FAIL beq_bptwe got=%b want=1", bptwe32); end
    total++; if (bptd32 !== {32'h400, 1'b1}) begin bad++; $display("FAIL beq_bptd got=%h want=000000801", bptd32); end
    total++; if (bpta32 !== 8'hAF) begin bad++; $display("FAIL beq_bpta got=%h want=af", bpta32); end
    total++; if (stall32 !== 1'b0) begin bad++; $display("FAIL beq_stall got=%b want=0", stall32); end
    npc = 64'h400; #1;
    total++; if (flush32 !== 1'b0) begin bad++; $display("FAIL beq_hit_flush got=%b want=0", flush32); end
    mem_ctrl = BNE; prediction = 0; #1;
    total++; if (br32 !== 1'b0 || flush32 !== 1'b0) begin bad++; $display("FAIL bne_nt got=%b%b want=00", br32, flush32); end
    alu = 64'h5; #1;
    total++; if (br32 !== 1'b1 || flush32 !== 1'b1) begin bad++; $display("FAIL bne_t got=%b%b want=11", br32, flush32); end
    mem_ctrl = NOBR; #1;
    total++; if (bptwe32 !== 1'b0 || flush32 !== 1'b0) begin bad++; $display("FAIL nobr got=%b%b want=00", bptwe32, flush32); end
    mem_ctrl = BEQ; alu = 0; ev32 = 0; #1;
    total++; if (br32 !== 1'b0 || bptwe32 !== 1'b0) begin bad++; $display("FAIL br_inv got=%b%b want=00", br32, bptwe32); end
    ev32 = 1; alu = 64'h33;
    @(posedge clk); #1;
    total++; if (wbv32 !== 1'b1 || wba32 !== 32'h33) begin bad++; $display("FAIL br_wb got=%b/%h want=1/33", wbv32, wba32); end
    ev32 = 0; mem_ctrl = NOBR; prediction = 0;
  endtask

  task automatic test_reset_mid_req;
    mem_ctrl = LW; alu = 64'h200; ev32 = 1; mem_ack = 0;
    @(posedge clk); #1;
    total++; if (req32 !== 1'b1) begin bad++; $display("FAIL mid_req_up got=%b want=1", req32); end
    #2 reset = 1'b0;
    #1;
    total++; if (req32 !== 1'b0) begin bad++; $display("FAIL mid_req_drop got=%b want=0", req32); end
    ev32 = 0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    total++; if (req32 !== 1'b0) begin bad++; $display("FAIL mid_req_idle got=%b want=0", req32); end
    mem_op(0, LW, 64'h300, 64'h0, 64'hCAFEF00D, 2);
    total++; if (wbm32 !== 32'hCAFEF00D) begin bad++; $display("FAIL mid_fresh_data got=%h want=cafef00d", wbm32); end
    total++; if (stalls !== 2) begin bad++; $display("FAIL mid_fresh_stalls got=%0d want=2", stalls); end
  endtask

  task automatic test_xlen64;
    mem_op(1, LD, 64'h108, 64'h0, 64'h0123456789ABCDEF, 2);
    total++; if (wbm64 !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL ld_data got=%h want=0123456789abcdef", wbm64); end
    total++; if (cap_be !== 8'hFF) begin bad++; $display("FAIL ld_be got=%h want=ff", cap_be); end
    total++; if (cap_addr !== 64'h108) begin bad++; $display("FAIL ld_addr got=%h want=108", cap_addr); end
    total++; if (stalls !== 2) begin bad++; $display("FAIL ld_stalls got=%0d want=2", stalls); end
    mem_op(1, LW, 64'h10C, 64'h0, 64'h8000000112345678, 1);
    total++; if (wbm64 !== 64'hFFFFFFFF80000001) begin bad++; $display("FAIL lw64_data got=%h want=ffffffff80000001", wbm64); end
    total++; if (cap_be !== 8'hF0 || cap_addr !== 64'h108) begin bad++; $display("FAIL lw64_be_addr got=%h/%h want=f0/108", cap_be, cap_addr); end
    mem_op(1, SB, 64'h10F, 64'hAB, 64'h0, 1);
    total++; if (cap_wdata !== 64'hABABABABABABABAB || cap_be !== 8'h80) begin bad++; $display("FAIL sb64 got=%h/%h want=abab..ab/80", cap_wdata, cap_be); end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_loads;
    test_stores;
    test_misalign;
    test_branch;
    test_reset_mid_req;
    test_xlen64;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
